fragment_sink: RTL and testbench

Receiving end of the render core's fragment stream. Accepts 32-bit fragments on a valid/ready/last handshake, buffers them in a small FIFO, and writes them in raster order into a linear framebuffer through a request/grant write port. It checks stream framing against the programmed image size and reports early or missing `last`. It sits between the render core and the framebuffer/DMA master inside the coprocessor.

---
 rtl/fragment_sink_if.sv | 29 ++
 rtl/fragment_sink.sv | 182 ++++++++++++++++++
 tb/tb_fragment_sink.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fragment_sink_if.sv
// Handshake bundles around fragment_sink: the incoming fragment stream and
// the outgoing framebuffer write port.

// Fragment stream: the producer is the master, fragment_sink is the slave.
interface frag_stream_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_last, output in_data, input in_ready);
  modport slave  (input in_valid, input in_last, input in_data, output in_ready);
endinterface

// Framebuffer write port: fragment_sink is the master, the memory side grants.
interface fb_write_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 24
);
  logic              fb_req;
  logic              fb_gnt;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  modport master (output fb_req, output fb_addr, output fb_data, input fb_gnt);
  modport slave  (input fb_req, input fb_addr, input fb_data, output fb_gnt);
endinterface

// File: rtl/fragment_sink.sv
// fragment_sink: receives a framed fragment stream, buffers it in a small
// FIFO and writes it in raster order to a linear framebuffer. Stream framing
// is checked against the image size latched on arm.
module fragment_sink #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DIM_W      = 16,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic [DIM_W-1:0]     width,
  input  logic [DIM_W-1:0]     height,
  input  logic [ADDR_W-1:0]    base_addr,
  frag_stream_if.slave         frag,
  fb_write_if.master           fb,
  output logic                 busy,
  output logic                 done,
  output logic                 err_early_last,
  output logic                 err_missing_last,
  output logic [2*DIM_W-1:0]   frag_count
);

  localparam int unsigned CNT_W = 2 * DIM_W;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W-1:0]    occ_next;

  // Frame context latched on arm
  logic [CNT_W-1:0]    n_total;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    write_index;

  logic                fifo_full;
  logic                fifo_empty;
  logic                writer_on;
  logic                push;
  logic                pop;
  logic                final_index;

  assign fifo_full   = (occ == OCC_W'(FIFO_DEPTH));
  assign fifo_empty  = (occ == '0);
  assign writer_on   = (state == S_RECV) || (state == S_DRAIN);

  // Ready depends only on state and occupancy, never on in_valid
  assign frag.in_ready = (state == S_RECV) && !fifo_full;
  assign push          = frag.in_valid && frag.in_ready;

  // Writer presents the FIFO head; address/data hold while the grant is low
  assign fb.fb_req  = writer_on && !fifo_empty;
  assign fb.fb_data = mem[rd_ptr];
  assign fb.fb_addr = base_q + ADDR_W'(write_index);
  assign pop        = fb.fb_req && fb.fb_gnt;

  assign busy = (state != S_IDLE);

  // Fragment being accepted now is the last one the image size allows
  assign final_index = (frag_count == (n_total - CNT_W'(1)));

  // Occupancy after this cycle's push/pop
  always_comb begin
    occ_next = occ;
    unique case ({push, pop})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= frag.in_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      occ <= occ_next;
    end
  end

  // Frame control FSM with framing checks, counters and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      n_total          <= '0;
      base_q           <= '0;
      write_index      <= '0;
      frag_count       <= '0;
      done             <= 1'b0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (arm) begin
            base_q           <= base_addr;
            n_total          <= CNT_W'(width) * CNT_W'(height);
            frag_count       <= '0;
            write_index      <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            // An empty image skips reception and goes straight to the pulse
            if ((width == '0) || (height == '0)) begin
              state <= S_DONE;
            end else begin
              state <= S_RECV;
            end
          end
        end

        S_RECV: begin
          if (push) begin
            frag_count <= frag_count + CNT_W'(1);
            if (frag.in_last && !final_index) begin
              err_early_last <= 1'b1;
              state          <= S_DRAIN;
            end else if (final_index) begin
              if (!frag.in_last) begin
                err_missing_last <= 1'b1;
              end
              state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Leave once the last buffered fragment has been granted
          if (occ_next == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          // Entered with done already set after a drain; an empty frame
          // raises it here first so the pulse lands two cycles after arm
          if (done) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase

      if (pop) begin
        write_index <= write_index + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fragment_sink.sv
// Directed bench for fragment_sink: one task per scenario with inline checks.
module tb_fragment_sink;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned DIM_W      = 16;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                arm;
  logic [DIM_W-1:0]    width;
  logic [DIM_W-1:0]    height;
  logic [ADDR_W-1:0]   base_addr;
  logic                busy;
  logic                done;
  logic                err_early_last;
  logic                err_missing_last;
  logic [2*DIM_W-1:0]  frag_count;

  frag_stream_if #(.DATA_W(DATA_W)) frag ();
  fb_write_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fb ();

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Written only by the monitor
  int done_cnt   = 0;
  int accept_cnt = 0;
  int stall_viol = 0;
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;

  fragment_sink #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .width(width), .height(height),
    .base_addr(base_addr), .frag(frag), .fb(fb), .busy(busy), .done(done),
    .err_early_last(err_early_last), .err_missing_last(err_missing_last),
    .frag_count(frag_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: log granted writes, accepts, done pulses and stall stability
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (fb.fb_req && fb.fb_gnt) begin
        wr_addr_q.push_back(fb.fb_addr);
        wr_data_q.push_back(fb.fb_data);
      end
      if (frag.in_valid && frag.in_ready) accept_cnt++;
      if (done) done_cnt++;
      if (prev_stall && (!fb.fb_req || fb.fb_addr !== prev_addr || fb.fb_data !== prev_data))
        stall_viol++;
      prev_stall = fb.fb_req && !fb.fb_gnt;
      prev_addr  = fb.fb_addr;
      prev_data  = fb.fb_data;
    end
  end

  task automatic do_arm(input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h,
                        input logic [ADDR_W-1:0] b);
    width = w; height = h; base_addr = b; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  // Present one fragment and hold it until accepted; leaves in_valid high
  task automatic push(input logic [DATA_W-1:0] d, input logic l);
    bit ok = 1'b0;
    frag.in_valid = 1'b1; frag.in_data = d; frag.in_last = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frag.in_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("FAIL push_timeout: in_ready got 0 expected 1 (data %h)", d);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen) passed++;
    else $display("FAIL %s_done_timeout: done got 0 expected 1", name);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; width = '0; height = '0; base_addr = '0;
    frag.in_valid = 1'b0; frag.in_last = 1'b0; frag.in_data = '0; fb.fb_gnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({frag.in_ready, fb.fb_req, busy, done, err_early_last, err_missing_last} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000",
               {frag.in_ready, fb.fb_req, busy, done, err_early_last, err_missing_last});
    else passed++;
    checks++;
    if ({fb.fb_addr, fb.fb_data, frag_count} !== '0)
      $display("FAIL reset_values: addr %h data %h count %0d expected all 0",
               fb.fb_addr, fb.fb_data, frag_count);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input logic [ADDR_W-1:0] b, input logic [DATA_W-1:0] d0,
                            input string name);
    int s = wr_addr_q.size();
    int dsnap = done_cnt;
    int t0, t1;
    fb.fb_gnt = 1'b1;
    do_arm(16'd4, 16'd2, b);
    checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy: got %b expected 1", name, busy);
    else passed++;
    t0 = cyc;
    for (int k = 0; k < 8; k++) push(d0 + DATA_W'(k), (k == 7));
    t1 = cyc;
    frag.in_valid = 1'b0; frag.in_last = 1'b0;
    checks++;
    if (t1 - t0 !== 8) $display("FAIL %s_throughput: got %0d cycles expected 8", name, t1 - t0);
    else passed++;
    wait_done(name);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (wr_addr_q.size() - s !== 8)
      $display("FAIL %s_write_count: got %0d expected 8", name, wr_addr_q.size() - s);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      logic [ADDR_W-1:0] ga = (s + k < wr_addr_q.size()) ? wr_addr_q[s+k] : 'x;
      logic [DATA_W-1:0] gd = (s + k < wr_data_q.size()) ? wr_data_q[s+k] : 'x;
      checks++;
      if ({ga, gd} !== {b + ADDR_W'(k), d0 + DATA_W'(k)})
        $display("FAIL %s_write%0d: got %h/%h expected %h/%h", name, k, ga, gd,
                 b + ADDR_W'(k), d0 + DATA_W'(k));
      else passed++;
    end
    checks++;
    if ({frag_count, err_early_last, err_missing_last, busy} !== {32'd8, 3'b000})
      $display("FAIL %s_status: count %0d early %b missing %b busy %b expected 8 0 0 0",
               name, frag_count, err_early_last, err_missing_last, busy);
    else passed++;
    checks++;
    if (done_cnt - dsnap !== 1) $display("FAIL %s_done_once: got %0d expected 1", name, done_cnt - dsnap);
    else passed++;
  endtask

  task automatic test_backpressure();
    int s = wr_addr_q.size();
    int a0 = accept_cnt;
    int v0 = stall_viol;
    int ready_hi = 0;
    logic [DATA_W-1:0] d0 = 32'hB000_0000;
    fb.fb_gnt = 1'b0;
    do_arm(16'd4, 16'd2, 24'h000100);
    for (int k = 0; k < 4; k++) push(d0 + DATA_W'(k), 1'b0);
    frag.in_valid = 1'b1; frag.in_data = d0 + 32'd4; frag.in_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (frag.in_ready) ready_hi++;
      if (c == 3) begin
        checks++;
        if ({fb.fb_req, fb.fb_addr, fb.fb_data} !== {1'b1, 24'h000100, d0})
          $display("FAIL bp_head_held: got %b %h %h expected 1 000100 %h",
                   fb.fb_req, fb.fb_addr, fb.fb_data, d0);
        else passed++;
      end
    end
    checks++;
    if (ready_hi !== 0) $display("FAIL bp_ready_low: got %0d ready cycles expected 0", ready_hi);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (accept_cnt - a0 !== 4) $display("FAIL bp_accepts_when_full: got %0d expected 4", accept_cnt - a0);
    else passed++;
    fb.fb_gnt = 1'b1;
    for (int k = 4; k < 8; k++) push(d0 + DATA_W'(k), (k == 7));
    frag.in_valid = 1'b0; frag.in_last = 1'b0;
    wait_done("bp");
    checks++;
    if (wr_addr_q.size() - s !== 8) $display("FAIL bp_write_count: got %0d expected 8", wr_addr_q.size() - s);
    else passed++;
    for (int k = 0; k < 8; k++) begin
      logic [ADDR_W-1:0] ga = (s + k < wr_addr_q.size()) ? wr_addr_q[s+k] : 'x;
      logic [DATA_W-1:0] gd = (s + k < wr_data_q.size()) ? wr_data_q[s+k] : 'x;
      checks++;
      if ({ga, gd} !== {24'h000100 + ADDR_W'(k), d0 + DATA_W'(k)})
        $display("FAIL bp_write%0d: got %h/%h expected %h/%h", k, ga, gd,
                 24'h000100 + ADDR_W'(k), d0 + DATA_W'(k));
      else passed++;
    end
    checks++;
    if (stall_viol - v0 !== 0) $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_viol - v0);
    else passed++;
  endtask

  task automatic test_early_last();
    int s = wr_addr_q.size();
    int dsnap = done_cnt;
    logic [DATA_W-1:0] d0 = 32'hC000_0000;
    fb.fb_gnt = 1'b1;
    do_arm(16'd3, 16'd3, 24'h000200);
    for (int k = 0; k < 5; k++) push(d0 + DATA_W'(k), (k == 4));
    frag.in_valid = 1'b1; frag.in_data = d0 + 32'd5; frag.in_last = 1'b0;
    @(negedge clk);
    checks++;
    if ({frag.in_ready, err_early_last, err_missing_last} !== 3'b010)
      $display("FAIL early_flags: ready/early/missing got %b expected 010",
               {frag.in_ready, err_early_last, err_missing_last});
    else passed++;
    frag.in_valid = 1'b0;
    wait_done("early");
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (wr_addr_q.size() - s !== 5) $display("FAIL early_write_count: got %0d expected 5", wr_addr_q.size() - s);
    else passed++;
    checks++;
    if ((s + 4 < wr_addr_q.size()) && {wr_addr_q[s+4], wr_data_q[s+4]} === {24'h000204, d0 + 32'd4}) passed++;
    else $display("FAIL early_last_write: got entry count %0d expected 000204/%h at index 4",
                  wr_addr_q.size() - s, d0 + 32'd4);
    checks++;
    if ({frag_count, err_early_last, done_cnt - dsnap} !== {32'd5, 1'b1, 32'd1})
      $display("FAIL early_status: count %0d early %b dones %0d expected 5 1 1",
               frag_count, err_early_last, done_cnt - dsnap);
    else passed++;
  endtask

  task automatic test_missing_last();
    int s = wr_addr_q.size();
    int a0 = accept_cnt;
    logic [DATA_W-1:0] d0 = 32'hD000_0000;
    fb.fb_gnt = 1'b1;
    do_arm(16'd2, 16'd2, 24'h000300);
    for (int k = 0; k < 4; k++) push(d0 + DATA_W'(k), 1'b0);
    frag.in_data = d0 + 32'd4;
    @(negedge clk);
    checks++;
    if ({frag.in_valid, frag.in_ready, err_early_last, err_missing_last} !== 4'b1001)
      $display("FAIL missing_flags: valid/ready/early/missing got %b expected 1001",
               {frag.in_valid, frag.in_ready, err_early_last, err_missing_last});
    else passed++;
    wait_done("missing");
    frag.in_valid = 1'b0;
    checks++;
    if ({accept_cnt - a0, wr_addr_q.size() - s} !== {32'd4, 32'd4})
      $display("FAIL missing_counts: accepts %0d writes %0d expected 4 4",
               accept_cnt - a0, wr_addr_q.size() - s);
    else passed++;
    checks++;
    if ((s + 3 < wr_addr_q.size()) && wr_addr_q[s+3] === 24'h000303) passed++;
    else $display("FAIL missing_last_addr: got entry count %0d expected 000303 at index 3",
                  wr_addr_q.size() - s);
  endtask

  task automatic test_zero_size();
    int s = wr_addr_q.size();
    do_arm(16'd0, 16'd5, 24'h000400);
    @(negedge clk);
    checks++;
    if ({done, busy, err_missing_last} !== 3'b010)
      $display("FAIL zero_cycle1: done/busy/missing got %b expected 010", {done, busy, err_missing_last});
    else passed++;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b11) $display("FAIL zero_cycle2: done/busy got %b expected 11", {done, busy});
    else passed++;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL zero_cycle3: done/busy got %b expected 00", {done, busy});
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (wr_addr_q.size() - s !== 0) $display("FAIL zero_no_writes: got %0d expected 0", wr_addr_q.size() - s);
    else passed++;
  endtask

  task automatic test_arm_busy();
    int s = wr_addr_q.size();
    fb.fb_gnt = 1'b1;
    do_arm(16'd2, 16'd1, 24'h000400);
    do_arm(16'd4, 16'd4, 24'h000500);
    push(32'hE000_0000, 1'b0);
    push(32'hE000_0001, 1'b1);
    frag.in_valid = 1'b0; frag.in_last = 1'b0;
    wait_done("arm_busy");
    checks++;
    if ((s + 1 < wr_addr_q.size()) && {wr_addr_q[s], wr_addr_q[s+1]} === {24'h000400, 24'h000401}) passed++;
    else $display("FAIL arm_busy_addrs: got %0d writes expected 000400,000401", wr_addr_q.size() - s);
    checks++;
    if ({frag_count, err_early_last, err_missing_last} !== {32'd2, 2'b00})
      $display("FAIL arm_busy_status: count %0d early %b missing %b expected 2 0 0",
               frag_count, err_early_last, err_missing_last);
    else passed++;
  endtask

  task automatic test_wrap();
    int s = wr_addr_q.size();
    logic [ADDR_W-1:0] exp_a [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    fb.fb_gnt = 1'b1;
    do_arm(16'd4, 16'd1, 24'hFFFFFE);
    for (int k = 0; k < 4; k++) push(32'hF000_0000 + DATA_W'(k), (k == 3));
    frag.in_valid = 1'b0; frag.in_last = 1'b0;
    wait_done("wrap");
    for (int k = 0; k < 4; k++) begin
      logic [ADDR_W-1:0] ga = (s + k < wr_addr_q.size()) ? wr_addr_q[s+k] : 'x;
      checks++;
      if (ga !== exp_a[k]) $display("FAIL wrap_addr%0d: got %h expected %h", k, ga, exp_a[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    fb.fb_gnt = 1'b0;
    do_arm(16'd4, 16'd2, 24'h000600);
    for (int k = 0; k < 3; k++) push(32'h6000_0000 + DATA_W'(k), 1'b0);
    frag.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({frag.in_ready, fb.fb_req, busy, done, err_early_last, err_missing_last} !== 6'b0)
      $display("FAIL midreset_ctrl: got %b expected 000000",
               {frag.in_ready, fb.fb_req, busy, done, err_early_last, err_missing_last});
    else passed++;
    checks++;
    if ({fb.fb_addr, fb.fb_data, frag_count} !== '0)
      $display("FAIL midreset_values: addr %h data %h count %0d expected all 0",
               fb.fb_addr, fb.fb_data, frag_count);
    else passed++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    test_basic(24'h000700, 32'h7000_0000, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic(24'h000100, 32'hA000_0000, "basic");
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_zero_size();
    test_arm_busy();
    test_wrap();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
